// File: rtl/uart_tx_sequencer.sv
// Byte FIFO that drains into a register-mapped UART: polls the status register
// until the transmitter is idle, then writes the head byte to the data register.
module uart_tx_sequencer #(
    parameter int unsigned DEPTH = 4  // power of two, 2..16
) (
    input  logic                     wb_clk_i,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     enable,
    input  logic                     clr_ovf,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic                     sent,
    output logic [2:0]               sp_addr,
    output logic [7:0]               sp_data,
    output logic                     sp_cyc,
    output logic                     sp_we,
    input  logic [7:0]               sp_rdata
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [2:0] SpReg = 3'd3;

    typedef enum logic [2:0] {
        StIdle,
        StPoll,
        StCheck,
        StWrite,
        StSettle
    } state_e;

    state_e state_q, state_d;

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          ovf_q;
    logic          sent_q;
    logic          sp_cyc_q, sp_cyc_d;
    logic          sp_we_q, sp_we_d;
    logic [2:0]    sp_addr_q, sp_addr_d;
    logic [7:0]    sp_data_q, sp_data_d;

    logic pop, push_ok, push_drop;

    // Only bit 0 of the status register (busy) matters here.
    logic unused_rdata;
    assign unused_rdata = ^sp_rdata[7:1];

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign level = count_q;
    assign ovf   = ovf_q;
    assign sent  = sent_q;
    assign sp_cyc  = sp_cyc_q;
    assign sp_we   = sp_we_q;
    assign sp_addr = sp_addr_q;
    assign sp_data = sp_data_q;

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign pop       = (state_q == StWrite) && !empty;
    assign push_ok   = push && (!full || pop);
    assign push_drop = push && full && !pop;

    always_ff @(posedge wb_clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (push_drop) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sp_cyc_d  = 1'b0;
        sp_we_d   = 1'b0;
        sp_addr_d = 3'd0;
        sp_data_d = 8'h00;
        unique case (state_q)
            StIdle:   if (enable && !empty) state_d = StPoll;
            StPoll:   state_d = StCheck;
            StCheck:  state_d = sp_rdata[0] ? StPoll : StWrite;
            StWrite:  state_d = StSettle;
            StSettle: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        // Bus outputs are registered, so decode them from the state being entered.
        unique case (state_d)
            StPoll: begin
                sp_cyc_d  = 1'b1;
                sp_addr_d = SpReg;
            end
            StWrite: begin
                sp_cyc_d  = 1'b1;
                sp_we_d   = 1'b1;
                sp_addr_d = SpReg;
                sp_data_d = mem[rd_ptr_q];
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            sent_q    <= 1'b0;
            sp_cyc_q  <= 1'b0;
            sp_we_q   <= 1'b0;
            sp_addr_q <= 3'd0;
            sp_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            sent_q    <= (state_q == StWrite);
            sp_cyc_q  <= sp_cyc_d;
            sp_we_q   <= sp_we_d;
            sp_addr_q <= sp_addr_d;
            sp_data_q <= sp_data_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer: a byte scoreboard checks every UART write,
// plus explicit checks of FIFO flags, poll counts, write spacing and reset behaviour.
module tb_uart_tx_sequencer;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic [7:0] push_data;
    logic       enable;
    logic       clr_ovf;
    logic       full, empty, ovf, sent;
    logic [$clog2(DEPTH):0] level;
    logic [2:0] sp_addr;
    logic [7:0] sp_data;
    logic       sp_cyc, sp_we;
    logic [7:0] sp_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int polls = 0;
    int writes = 0;
    int sents = 0;
    int prev_write = 0;
    bit have_prev = 0;
    bit check_gap = 0;
    bit seen_write = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_sequencer #(.DEPTH(DEPTH)) dut (
        .wb_clk_i (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_data),
        .enable   (enable),
        .clr_ovf  (clr_ovf),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .ovf      (ovf),
        .sent     (sent),
        .sp_addr  (sp_addr),
        .sp_data  (sp_data),
        .sp_cyc   (sp_cyc),
        .sp_we    (sp_we),
        .sp_rdata (sp_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled on the falling edge and fed to the bus monitor.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (sp_cyc && !sp_we) begin
            polls++;
            chk("poll_addr", 32'(sp_addr), 32'd3);
        end
        if (sp_cyc && sp_we) begin
            writes++;
            seen_write = 1;
            chk("write_addr", 32'(sp_addr), 32'd3);
            chk("write_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("write_data", 32'(sp_data), 32'(exp_q.pop_front()));
            if (check_gap && have_prev) chk("write_gap", 32'(cyc - prev_write), 32'd5);
            prev_write = cyc;
            have_prev = 1;
        end
        if (sent) sents++;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit expect_kept);
        push = 1'b1;
        push_data = b;
        if (expect_kept) exp_q.push_back(b);
        step();
        push = 1'b0;
    endtask

    int p0, w0, s0;

    initial begin
        rst = 1'b1;
        push = 1'b0;
        push_data = 8'h00;
        enable = 1'b0;
        clr_ovf = 1'b0;
        sp_rdata = 8'h00;
        repeat (3) step();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_sent", 32'(sent), 32'd0);
        chk("rst_bus", {sp_cyc, sp_we, sp_addr, sp_data}, 32'd0);
        rst = 1'b0;
        step();

        // Single byte, UART idle: IDLE, POLL, CHECK, WRITE, SETTLE(sent), IDLE.
        enable = 1'b1;
        push_byte(8'h41, 1);
        chk("s1_no_early_poll", 32'(sp_cyc), 32'd0);
        step();
        chk("s1_poll", {sp_cyc, sp_we, sp_addr}, {1'b1, 1'b0, 3'd3});
        step();
        chk("s1_check_cyc", 32'(sp_cyc), 32'd0);
        step();
        chk("s1_write", {sp_cyc, sp_we, sp_addr, sp_data}, {1'b1, 1'b1, 3'd3, 8'h41});
        chk("s1_write_sent_low", 32'(sent), 32'd0);
        step();
        chk("s1_sent", 32'(sent), 32'd1);
        chk("s1_settle_cyc", 32'(sp_cyc), 32'd0);
        chk("s1_empty", 32'(empty), 32'd1);
        step();
        chk("s1_sent_one_cycle", 32'(sent), 32'd0);
        repeat (4) step();
        chk("s1_polls", 32'(polls), 32'd1);
        chk("s1_writes", 32'(writes), 32'd1);
        chk("s1_sents", 32'(sents), 32'd1);

        // UART busy for the first three polls.
        p0 = polls; w0 = writes;
        sp_rdata = 8'h01;
        push_byte(8'h42, 1);
        for (int i = 0; i < 40; i++) begin
            step();
            if (polls - p0 == 4) sp_rdata = 8'h00;
        end
        chk("busy_polls", 32'(polls - p0), 32'd4);
        chk("busy_writes", 32'(writes - w0), 32'd1);
        sp_rdata = 8'h00;

        // Overflow with draining disabled; set wins over a simultaneous clear.
        enable = 1'b0;
        push_byte(8'hA0, 1);
        push_byte(8'hA1, 1);
        push_byte(8'hA2, 1);
        push_byte(8'hA3, 1);
        chk("ovf_before_drop", 32'(ovf), 32'd0);
        push_byte(8'hA4, 0);
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_set", 32'(ovf), 32'd1);
        clr_ovf = 1'b1;
        push_byte(8'hA5, 0);
        chk("ovf_set_wins", 32'(ovf), 32'd1);
        step();
        clr_ovf = 1'b0;
        chk("ovf_cleared", 32'(ovf), 32'd0);
        chk("ovf_level_kept", 32'(level), 32'd4);
        w0 = writes;
        check_gap = 1; have_prev = 0;
        enable = 1'b1;
        repeat (30) step();
        chk("ovf_drain_writes", 32'(writes - w0), 32'd4);
        chk("ovf_drain_empty", 32'(empty), 32'd1);

        // Three bytes streamed with the UART idle.
        w0 = writes; s0 = sents; have_prev = 0;
        push_byte(8'h10, 1);
        push_byte(8'h20, 1);
        push_byte(8'h30, 1);
        repeat (25) step();
        chk("stream_writes", 32'(writes - w0), 32'd3);
        chk("stream_sents", 32'(sents - s0), 32'd3);

        // Push into a full FIFO during the WRITE cycle.
        enable = 1'b0;
        push_byte(8'hB0, 1);
        push_byte(8'hB1, 1);
        push_byte(8'hB2, 1);
        push_byte(8'hB3, 1);
        chk("wpush_full", 32'(full), 32'd1);
        w0 = writes; have_prev = 0; seen_write = 0;
        enable = 1'b1;
        for (int i = 0; i < 20 && !seen_write; i++) step();
        chk("wpush_write_seen", 32'(seen_write), 32'd1);
        push_byte(8'h99, 1);
        chk("wpush_level", 32'(level), 32'd4);
        chk("wpush_ovf", 32'(ovf), 32'd0);
        repeat (30) step();
        chk("wpush_writes", 32'(writes - w0), 32'd5);
        chk("wpush_empty", 32'(empty), 32'd1);

        // Reset asserted during WRITE aborts and flushes.
        check_gap = 0;
        enable = 1'b0;
        push_byte(8'h55, 1);
        push_byte(8'h56, 0);
        seen_write = 0;
        enable = 1'b1;
        for (int i = 0; i < 20 && !seen_write; i++) step();
        chk("rstw_write_seen", 32'(seen_write), 32'd1);
        s0 = sents;
        rst = 1'b1;
        #1;
        chk("rstw_async_cyc", 32'(sp_cyc), 32'd0);
        chk("rstw_async_bus", {sp_we, sp_addr, sp_data}, 32'd0);
        chk("rstw_level", 32'(level), 32'd0);
        chk("rstw_empty", 32'(empty), 32'd1);
        step();
        rst = 1'b0;
        p0 = polls; w0 = writes;
        repeat (10) step();
        chk("rstw_no_sent", 32'(sents - s0), 32'd0);
        chk("rstw_no_poll", 32'(polls - p0), 32'd0);
        chk("rstw_no_write", 32'(writes - w0), 32'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
